// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle sequencer for the RV32I core. Each instruction is stepped
//   through FETCH -> DECODE -> EXEC -> [MEM] -> [WB], driving the per-class
//   datapath controls, PC/IR strobes and the req/ack handshakes to
//   instruction and data memory. It also keeps a retired-instruction counter
//   and a sticky trap for illegal opcodes and memory timeouts.
//
// Parameters
//   MEM_TIMEOUT  max cycles a memory request may stay unacked (1..255)
//   CNT_W        width of the wait counter (must hold MEM_TIMEOUT)
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_OPCode[6:0]         opcode field of the instruction register
//   i_IMemAck/i_DMemAck   memory acknowledges
//   i_Stall               external hold (DECODE/EXEC/WB only)
//   i_TrapClr             leaves TRAP and restarts fetch
//   o_IMemReq/o_DMemReq   memory requests, o_DMemWe store enable
//   o_IRWrite/o_PCWrite   IR load / PC update strobes, o_Branch PC mux select
//   o_ALUOp[2:0]/o_ALUSrc ALU class and operand-B select
//   o_RegWrite/o_MemToReg register file write and writeback source
//   o_Trap/o_TrapCause    sticky trap and cause (01 illegal, 10 imem, 11 dmem)
//   o_InstRet[31:0]       retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_OPCode,
    input  logic        i_IMemAck,
    input  logic        i_DMemAck,
    input  logic        i_Stall,
    input  logic        i_TrapClr,
    output logic        o_IMemReq,
    output logic        o_DMemReq,
    output logic        o_DMemWe,
    output logic        o_IRWrite,
    output logic        o_PCWrite,
    output logic        o_Branch,
    output logic [2:0]  o_ALUOp,
    output logic        o_ALUSrc,
    output logic        o_RegWrite,
    output logic        o_MemToReg,
    output logic        o_Trap,
    output logic [1:0]  o_TrapCause,
    output logic [31:0] o_InstRet
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_I      = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_LUI    = 3'd6
    } class_t;

    state_t             r_State;
    state_t             w_NextState;
    class_t             r_Class;
    class_t             w_DecClass;
    logic [CNT_W-1:0]   r_WaitCnt;
    logic [1:0]         r_Cause;
    logic [31:0]        r_InstRet;
    logic               w_Ack;
    logic               w_Timeout;
    logic               w_Waiting;

    // Opcode -> class
    always_comb begin
        w_DecClass = C_NONE;
        case (i_OPCode)
            7'b0110011: w_DecClass = C_R;
            7'b0010011: w_DecClass = C_I;
            7'b0000011: w_DecClass = C_LOAD;
            7'b0100011: w_DecClass = C_STORE;
            7'b1100011: w_DecClass = C_BRANCH;
            7'b0110111: w_DecClass = C_LUI;
            default:    w_DecClass = C_NONE;
        endcase
    end

    // Handshake bookkeeping: only the ack matching the live request counts,
    // so stray acks in other states never move the machine.
    assign w_Waiting = (r_State == S_FETCH) || (r_State == S_MEM);
    assign w_Ack     = (r_State == S_FETCH) ? i_IMemAck : i_DMemAck;
    // Counter holds the number of unacked cycles already spent; the cycle in
    // which it equals MEM_TIMEOUT-1 is the last one allowed. Ack is checked
    // first so an ack in that final cycle still wins.
    assign w_Timeout = (r_WaitCnt == CNT_W'(MEM_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_State <= S_FETCH;
        else          r_State <= w_NextState;
    end

    // Next-state logic
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            S_FETCH: begin
                if (i_IMemAck)      w_NextState = S_DECODE;
                else if (w_Timeout) w_NextState = S_TRAP;
            end
            S_DECODE: begin
                if (!i_Stall)
                    w_NextState = (w_DecClass == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (!i_Stall) begin
                    case (r_Class)
                        C_BRANCH:        w_NextState = S_FETCH;
                        C_LOAD, C_STORE: w_NextState = S_MEM;
                        default:         w_NextState = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (i_DMemAck)
                    w_NextState = (r_Class == C_STORE) ? S_FETCH : S_WB;
                else if (w_Timeout)
                    w_NextState = S_TRAP;
            end
            S_WB: begin
                if (!i_Stall) w_NextState = S_FETCH;
            end
            S_TRAP: begin
                if (i_TrapClr) w_NextState = S_FETCH;
            end
            default: w_NextState = S_FETCH;
        endcase
    end

    // Datapath bookkeeping: class latch, wait counter, trap cause, retire count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_Class   <= C_NONE;
            r_WaitCnt <= '0;
            r_Cause   <= 2'b00;
            r_InstRet <= '0;
        end else begin
            if (r_State == S_DECODE && !i_Stall)
                r_Class <= w_DecClass;

            // Counter is zero outside FETCH/MEM, so every entry starts clean.
            if (w_Waiting && !w_Ack && !w_Timeout)
                r_WaitCnt <= r_WaitCnt + 1'b1;
            else
                r_WaitCnt <= '0;

            if (r_State != S_TRAP && w_NextState == S_TRAP) begin
                case (r_State)
                    S_DECODE: r_Cause <= 2'b01;
                    S_FETCH:  r_Cause <= 2'b10;
                    default:  r_Cause <= 2'b11;
                endcase
            end else if (r_State == S_TRAP && i_TrapClr) begin
                r_Cause <= 2'b00;
            end

            // Every PCWrite pulse retires an instruction.
            if (o_PCWrite)
                r_InstRet <= r_InstRet + 32'd1;
        end
    end

    // Output logic. Gated by reset so requests drop the moment reset is
    // asserted even though the state register already reads FETCH.
    always_comb begin
        o_IMemReq  = 1'b0;
        o_DMemReq  = 1'b0;
        o_DMemWe   = 1'b0;
        o_IRWrite  = 1'b0;
        o_PCWrite  = 1'b0;
        o_Branch   = 1'b0;
        o_ALUOp    = 3'b000;
        o_ALUSrc   = 1'b0;
        o_RegWrite = 1'b0;
        o_MemToReg = 1'b0;
        o_Trap     = 1'b0;
        if (i_rst_n) begin
            // ALU controls follow the latched class through EXEC and MEM
            // (MEM still needs the address add).
            if (r_State == S_EXEC || r_State == S_MEM) begin
                case (r_Class)
                    C_R:             begin o_ALUOp = 3'b010; o_ALUSrc = 1'b0; end
                    C_I:             begin o_ALUOp = 3'b011; o_ALUSrc = 1'b1; end
                    C_LOAD, C_STORE: begin o_ALUOp = 3'b000; o_ALUSrc = 1'b1; end
                    C_BRANCH:        begin o_ALUOp = 3'b001; o_ALUSrc = 1'b0; end
                    C_LUI:           begin o_ALUOp = 3'b100; o_ALUSrc = 1'b0; end
                    default:         begin o_ALUOp = 3'b000; o_ALUSrc = 1'b0; end
                endcase
            end
            case (r_State)
                S_FETCH: begin
                    o_IMemReq = 1'b1;
                    o_IRWrite = i_IMemAck;
                end
                S_EXEC: begin
                    if (r_Class == C_BRANCH && !i_Stall) begin
                        o_Branch  = 1'b1;
                        o_PCWrite = 1'b1;
                    end
                end
                S_MEM: begin
                    o_DMemReq = 1'b1;
                    o_DMemWe  = (r_Class == C_STORE);
                    o_PCWrite = (r_Class == C_STORE) && i_DMemAck;
                end
                S_WB: begin
                    o_RegWrite = !i_Stall;
                    o_PCWrite  = !i_Stall;
                    o_MemToReg = (r_Class == C_LOAD);
                end
                S_TRAP: o_Trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_TrapCause = r_Cause;
    assign o_InstRet   = r_InstRet;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imem_ack, dmem_ack, stall, trap_clr;
    logic        o_IMemReq, o_DMemReq, o_DMemWe, o_IRWrite, o_PCWrite, o_Branch;
    logic [2:0]  o_ALUOp;
    logic        o_ALUSrc, o_RegWrite, o_MemToReg, o_Trap;
    logic [1:0]  o_TrapCause;
    logic [31:0] o_InstRet;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_ret = 0;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_OPCode(opcode),
        .i_IMemAck(imem_ack), .i_DMemAck(dmem_ack), .i_Stall(stall), .i_TrapClr(trap_clr),
        .o_IMemReq(o_IMemReq), .o_DMemReq(o_DMemReq), .o_DMemWe(o_DMemWe),
        .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite), .o_Branch(o_Branch),
        .o_ALUOp(o_ALUOp), .o_ALUSrc(o_ALUSrc), .o_RegWrite(o_RegWrite),
        .o_MemToReg(o_MemToReg), .o_Trap(o_Trap), .o_TrapCause(o_TrapCause),
        .o_InstRet(o_InstRet)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and return the handshake/strobe inputs
    // to idle; the caller then drives what the cycle needs and waits #1.
    task automatic next_cycle();
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; trap_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 7'd0;
        imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; trap_clr = 1'b0;
        #1;
        n_vec++; if (o_IMemReq !== 1'b0) begin n_err++; $display("FAIL rst_imemreq: got %b want 0", o_IMemReq); end
        n_vec++; if (o_InstRet !== 32'd0) begin n_err++; $display("FAIL rst_instret: got %h want 0", o_InstRet); end
        n_vec++; if ({o_Trap, o_TrapCause, o_ALUOp} !== 6'd0) begin n_err++; $display("FAIL rst_outs: got %b want 000000", {o_Trap, o_TrapCause, o_ALUOp}); end
        next_cycle(); next_cycle();
        rst_n = 1'b1; #1;
        n_vec++; if (o_IMemReq !== 1'b1) begin n_err++; $display("FAIL rst_fetch_req: got %b want 1", o_IMemReq); end
    endtask

    task automatic test_rtype();
        next_cycle(); opcode = OP_R; imem_ack = 1'b1; #1;   // cycle 1: FETCH, zero-wait ack
        n_vec++; if (o_IRWrite !== 1'b1) begin n_err++; $display("FAIL rt_irwrite: got %b want 1", o_IRWrite); end
        next_cycle(); #1;                                    // cycle 2: DECODE
        n_vec++; if ({o_IRWrite, o_IMemReq} !== 2'b00) begin n_err++; $display("FAIL rt_decode: got %b want 00", {o_IRWrite, o_IMemReq}); end
        next_cycle(); #1;                                    // cycle 3: EXEC
        n_vec++; if ({o_ALUOp, o_ALUSrc} !== 4'b0100) begin n_err++; $display("FAIL rt_exec_alu: got %b want 0100", {o_ALUOp, o_ALUSrc}); end
        next_cycle(); #1;                                    // cycle 4: WB
        n_vec++; if ({o_RegWrite, o_PCWrite, o_MemToReg} !== 3'b110) begin n_err++; $display("FAIL rt_wb: got %b want 110", {o_RegWrite, o_PCWrite, o_MemToReg}); end
        next_cycle(); #1; exp_ret = 32'd1;
        n_vec++; if (o_InstRet !== exp_ret) begin n_err++; $display("FAIL rt_instret: got %0d want %0d", o_InstRet, exp_ret); end
    endtask

    task automatic test_load_store();
        int req_cycles;
        next_cycle(); opcode = OP_LD; imem_ack = 1'b1;
        next_cycle();                                        // DECODE
        next_cycle(); #1;                                    // EXEC
        n_vec++; if ({o_ALUOp, o_ALUSrc} !== 4'b0001) begin n_err++; $display("FAIL ld_exec_alu: got %b want 0001", {o_ALUOp, o_ALUSrc}); end
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin                    // MEM, ack on 4th cycle
            next_cycle(); dmem_ack = (i == 3); #1;
            if (o_DMemReq === 1'b1 && o_DMemWe === 1'b0) req_cycles++;
        end
        n_vec++; if (req_cycles !== 4) begin n_err++; $display("FAIL ld_dmemreq_cycles: got %0d want 4", req_cycles); end
        next_cycle(); #1;                                    // WB
        n_vec++; if ({o_MemToReg, o_RegWrite, o_PCWrite} !== 3'b111) begin n_err++; $display("FAIL ld_wb: got %b want 111", {o_MemToReg, o_RegWrite, o_PCWrite}); end
        exp_ret++;
        next_cycle(); opcode = OP_ST; imem_ack = 1'b1;
        next_cycle(); next_cycle();
        next_cycle(); dmem_ack = 1'b1; #1;                   // MEM, zero-wait ack
        n_vec++; if ({o_DMemReq, o_DMemWe, o_PCWrite, o_RegWrite} !== 4'b1110) begin n_err++; $display("FAIL st_mem: got %b want 1110", {o_DMemReq, o_DMemWe, o_PCWrite, o_RegWrite}); end
        exp_ret++;
        next_cycle(); #1;
        n_vec++; if ({o_IMemReq, o_RegWrite} !== 2'b10) begin n_err++; $display("FAIL st_back_fetch: got %b want 10", {o_IMemReq, o_RegWrite}); end
        n_vec++; if (o_InstRet !== exp_ret) begin n_err++; $display("FAIL st_instret: got %0d want %0d", o_InstRet, exp_ret); end
    endtask

    task automatic test_illegal();
        next_cycle(); opcode = OP_BAD; imem_ack = 1'b1;
        next_cycle();                                        // DECODE
        next_cycle(); #1;                                    // TRAP
        n_vec++; if ({o_Trap, o_TrapCause} !== 3'b101) begin n_err++; $display("FAIL ill_trap: got %b want 101", {o_Trap, o_TrapCause}); end
        n_vec++; if ({o_IMemReq, o_DMemReq, o_PCWrite} !== 3'b000) begin n_err++; $display("FAIL ill_reqs: got %b want 000", {o_IMemReq, o_DMemReq, o_PCWrite}); end
        next_cycle(); imem_ack = 1'b1; dmem_ack = 1'b1; #1;  // sticky, stray acks ignored
        n_vec++; if ({o_Trap, o_TrapCause} !== 3'b101) begin n_err++; $display("FAIL ill_sticky: got %b want 101", {o_Trap, o_TrapCause}); end
        next_cycle(); trap_clr = 1'b1;
        next_cycle(); #1;
        n_vec++; if ({o_Trap, o_TrapCause, o_IMemReq} !== 4'b0001) begin n_err++; $display("FAIL ill_clear: got %b want 0001", {o_Trap, o_TrapCause, o_IMemReq}); end
        n_vec++; if (o_InstRet !== exp_ret) begin n_err++; $display("FAIL ill_instret: got %0d want %0d", o_InstRet, exp_ret); end
    endtask

    task automatic test_imem_timeout();
        int req_cycles;
        req_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) next_cycle();
            #1; if (o_IMemReq === 1'b1) req_cycles++;
        end
        n_vec++; if (req_cycles !== 15) begin n_err++; $display("FAIL ito_req_cycles: got %0d want 15", req_cycles); end
        next_cycle(); #1;
        n_vec++; if ({o_Trap, o_TrapCause, o_IMemReq} !== 4'b1100) begin n_err++; $display("FAIL ito_trap: got %b want 1100", {o_Trap, o_TrapCause, o_IMemReq}); end
        next_cycle(); trap_clr = 1'b1;
        for (int i = 0; i < 14; i++) next_cycle();           // FETCH cycles 1..14 unacked
        next_cycle(); opcode = OP_I; imem_ack = 1'b1; #1;    // ack on cycle 15
        n_vec++; if (o_IRWrite !== 1'b1) begin n_err++; $display("FAIL ito_ack15_ir: got %b want 1", o_IRWrite); end
        next_cycle(); #1;
        n_vec++; if ({o_Trap, o_IMemReq} !== 2'b00) begin n_err++; $display("FAIL ito_ack15_decode: got %b want 00", {o_Trap, o_IMemReq}); end
        next_cycle(); #1;
        n_vec++; if ({o_ALUOp, o_ALUSrc} !== 4'b0111) begin n_err++; $display("FAIL ito_i_exec: got %b want 0111", {o_ALUOp, o_ALUSrc}); end
        next_cycle(); exp_ret++;
        next_cycle(); #1;
        n_vec++; if (o_InstRet !== exp_ret) begin n_err++; $display("FAIL ito_instret: got %0d want %0d", o_InstRet, exp_ret); end
    endtask

    task automatic test_dmem_timeout();
        next_cycle(); opcode = OP_LD; imem_ack = 1'b1;
        next_cycle(); next_cycle();
        for (int i = 0; i < 15; i++) next_cycle();           // 15 unacked MEM cycles
        next_cycle(); #1;
        n_vec++; if ({o_Trap, o_TrapCause, o_DMemReq} !== 4'b1110) begin n_err++; $display("FAIL dto_trap: got %b want 1110", {o_Trap, o_TrapCause, o_DMemReq}); end
        next_cycle(); trap_clr = 1'b1;
        next_cycle(); #1;
        n_vec++; if ({o_Trap, o_IMemReq} !== 2'b01) begin n_err++; $display("FAIL dto_clear: got %b want 01", {o_Trap, o_IMemReq}); end
    endtask

    task automatic test_stall_branch();
        int pulses;
        next_cycle(); opcode = OP_BR; imem_ack = 1'b1;
        next_cycle();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); stall = 1'b1; #1;
            if (o_Branch === 1'b1 || o_PCWrite === 1'b1) pulses++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL br_stall_pulses: got %0d want 0", pulses); end
        n_vec++; if (o_ALUOp !== 3'b001) begin n_err++; $display("FAIL br_aluop: got %b want 001", o_ALUOp); end
        next_cycle(); #1;
        n_vec++; if ({o_Branch, o_PCWrite} !== 2'b11) begin n_err++; $display("FAIL br_release: got %b want 11", {o_Branch, o_PCWrite}); end
        exp_ret++;
        next_cycle(); #1;
        n_vec++; if ({o_Branch, o_PCWrite, o_IMemReq} !== 3'b001) begin n_err++; $display("FAIL br_one_pulse: got %b want 001", {o_Branch, o_PCWrite, o_IMemReq}); end
        n_vec++; if (o_InstRet !== exp_ret) begin n_err++; $display("FAIL br_instret: got %0d want %0d", o_InstRet, exp_ret); end
    endtask

    task automatic test_wrap();
        force dut.r_InstRet = 32'hFFFF_FFFF;
        #1;
        release dut.r_InstRet;
        next_cycle(); opcode = OP_R; imem_ack = 1'b1;
        next_cycle(); next_cycle(); next_cycle();            // DECODE, EXEC, WB
        next_cycle(); #1;
        n_vec++; if (o_InstRet !== 32'd0) begin n_err++; $display("FAIL wrap_instret: got %h want 00000000", o_InstRet); end
    endtask

    task automatic test_reset_mid_mem();
        next_cycle(); opcode = OP_ST; imem_ack = 1'b1;
        next_cycle(); next_cycle();
        next_cycle(); #1;                                    // MEM, no ack
        n_vec++; if (o_DMemReq !== 1'b1) begin n_err++; $display("FAIL rmm_in_mem: got %b want 1", o_DMemReq); end
        rst_n = 1'b0; #1;                                    // asynchronous, mid-cycle
        n_vec++; if ({o_DMemReq, o_DMemWe, o_IMemReq} !== 3'b000) begin n_err++; $display("FAIL rmm_async_drop: got %b want 000", {o_DMemReq, o_DMemWe, o_IMemReq}); end
        n_vec++; if (o_InstRet !== 32'd0) begin n_err++; $display("FAIL rmm_instret: got %h want 0", o_InstRet); end
        next_cycle(); rst_n = 1'b1; #1;
        n_vec++; if ({o_IMemReq, o_DMemReq} !== 2'b10) begin n_err++; $display("FAIL rmm_fetch: got %b want 10", {o_IMemReq, o_DMemReq}); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_stall_branch();
        test_wrap();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the same per-class datapath controls as the single-cycle decoder (ALUOp, ALUSrc, RegWrite, MemToReg, Branch), plus PC/IR write strobes and req/ack handshakes to instruction and data memory.
- Adds an instruction-retired counter and a sticky trap path for illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may stay unacknowledged before trapping; legal range 1..255.
- CNT_W, 8: width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_OPCode  input  7  opcode field of the instruction register (IR)
- i_IMemAck  input  1  instruction memory ack
- i_DMemAck  input  1  data memory ack
- i_Stall  input  1  external hold
- i_TrapClr  input  1  clears trap, restarts fetch
- o_IMemReq  output  1  instruction fetch request
- o_DMemReq  output  1  data access request
- o_DMemWe  output  1  data write enable (store)
- o_IRWrite  output  1  IR load strobe
- o_PCWrite  output  1  PC update strobe
- o_Branch  output  1  branch-select for PC mux
- o_ALUOp  output  3  ALU control class
- o_ALUSrc  output  1  0 = rs2, 1 = immediate
- o_RegWrite  output  1  register file write strobe
- o_MemToReg  output  1  writeback source: 1 = memory
- o_Trap  output  1  sticky trap flag
- o_TrapCause  output  2  01 illegal, 10 imem timeout, 11 dmem timeout
- o_InstRet  output  32  retired-instruction count

Behaviour:
- Reset (async, i_rst_n = 0):
  - State = FETCH. Wait counter = 0. Latched opcode class = none. o_InstRet = 0.
  - Every output = 0, including o_ALUOp = 000 and o_TrapCause = 00.
  - Requests drop immediately, even mid-transaction.
  - o_IMemReq rises combinationally in FETCH, i.e. in the first cycle after reset release.
- Opcode classes and EXEC controls (o_ALUOp / o_ALUSrc):
  - R 0110011: 010 / 0
  - I 0010011: 011 / 1
  - LOAD 0000011: 000 / 1
  - STORE 0100011: 000 / 1
  - BRANCH 1100011: 001 / 0
  - LUI 0110111: 100 / 0
- FETCH:
  - o_IMemReq held high until i_IMemAck is sampled high at a clock edge. A zero-wait ack in the first cycle is legal.
  - On ack: o_IRWrite = 1 for that cycle only, next state DECODE.
- DECODE:
  - Class latched from i_OPCode.
  - Known class -> EXEC.
  - Unknown class -> TRAP with cause 01.
- EXEC: o_ALUOp and o_ALUSrc driven per class.
  - BRANCH: o_Branch = 1 and o_PCWrite = 1 for one cycle, o_InstRet++, -> FETCH.
  - LOAD or STORE -> MEM.
  - R, I, LUI -> WB.
- MEM:
  - o_DMemReq held, with o_DMemWe = 1 for STORE. Address ALU controls stay driven.
  - On ack, STORE: o_PCWrite pulse, o_InstRet++, -> FETCH.
  - On ack, LOAD: -> WB.
- WB:
  - o_RegWrite = 1 for one cycle (LUI included).
  - o_MemToReg = 1 for LOAD only.
  - o_PCWrite = 1, o_InstRet++, -> FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle the request is unacked.
  - Reaching MEM_TIMEOUT without ack -> TRAP with cause 10 (FETCH) or 11 (MEM). The request deasserts.
  - Ack in the same cycle the counter hits MEM_TIMEOUT: ack wins.
- i_Stall:
  - In DECODE, EXEC or WB: state holds and all strobes (IRWrite, PCWrite, RegWrite, Branch) are suppressed.
  - In FETCH and MEM: ignored. The request and handshake continue.
- Stray acks (ack while the matching request is low) are ignored.
- TRAP:
  - o_Trap = 1. o_TrapCause holds the cause; all requests and strobes = 0.
  - Only i_TrapClr exits: -> FETCH next cycle, o_Trap and o_TrapCause return to 0.
  - i_TrapClr outside TRAP is ignored.
- o_InstRet wraps from 0xFFFFFFFF to 0. It increments only on retiring PCWrite pulses.
- Latency with zero-wait memory, counted from the o_IMemReq rise to the o_PCWrite pulse inclusive:
  - R/I/LUI: 4 cycles
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles

Test Plan:
- R-type 0110011, ack immediately -> IRWrite at cycle 1; EXEC ALUOp = 010, ALUSrc = 0; WB RegWrite = 1, PCWrite = 1 at cycle 4; o_InstRet = 1.
- LOAD 0000011 with DMemAck delayed 3 cycles -> DMemReq high 4 cycles, DMemWe = 0; WB MemToReg = 1, RegWrite = 1. Then STORE 0100011 -> DMemWe = 1, no RegWrite.
- Opcode 1111111 -> TRAP, o_TrapCause = 01, all requests 0. i_TrapClr pulse -> FETCH next cycle, o_Trap = 0.
- IMemAck withheld with MEM_TIMEOUT = 15 -> trap cause 10 after 15 cycles. Repeat with ack on the 15th cycle -> no trap, DECODE.
- i_Stall high 3 cycles in EXEC of a BRANCH -> no Branch/PCWrite during the stall; one pulse after release.
- Preload o_InstRet to 0xFFFFFFFF (via 2^32-1 retires or force), retire once -> 0. Assert reset mid-MEM -> DMemReq 0 asynchronously, state FETCH.
